// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the elastic pipeline-register chain.
package pipe_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int DEF_WIDTH  = 32;

  // Occupancy counts 0..depth inclusive, so it needs one value more than depth.
  function automatic int occW(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_state_t;

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a valid bit plus a payload register, with load, hold and kill.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             srcValid,
  input  logic [WIDTH-1:0] srcData,
  input  logic             kill,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A held entry can be killed; a loading stage takes the source's
  // qualified valid instead, so the kill is already applied upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= srcValid;
      if (srcValid) data <= srcData;
    end else begin
      valid <= valid && !kill;
    end
  end

endmodule

// File: rtl/pipe_stage_array.sv
// DEPTH-stage valid/ready pipeline with bubble collapse and per-stage flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / kill_cnt performance counters.
module pipe_stage_array
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int OCC_W = occW(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] flush,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] kill_cnt
`endif
);

  logic [DEPTH:0]                rdy;
  logic [DEPTH-1:0]              v, srcValid, nextV;
  logic [DEPTH-1:0][WIDTH-1:0]   d, srcData;
  logic [OCC_W-1:0]              nextOcc;

  // Ready ripples back from the output on raw valid only, so flush never
  // reaches in_ready.
  assign rdy[DEPTH] = out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : gStage
      assign rdy[i] = !v[i] || rdy[i+1];
      if (i == 0) begin : gHead
        assign srcValid[i] = in_valid;
        assign srcData[i]  = in_data;
      end else begin : gBody
        assign srcValid[i] = v[i-1] && !flush[i-1];
        assign srcData[i]  = d[i-1];
      end
      assign nextV[i] = rdy[i] ? srcValid[i] : (v[i] && !flush[i]);

      pipe_stage #(.WIDTH(WIDTH)) uStage (
        .clk      (clk),
        .rst      (rst),
        .load     (rdy[i]),
        .srcValid (srcValid[i]),
        .srcData  (srcData[i]),
        .kill     (flush[i]),
        .valid    (v[i]),
        .data     (d[i])
      );
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    nextOcc = '0;
    for (int i = 0; i < DEPTH; i++) nextOcc = nextOcc + OCC_W'(nextV[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occupancy <= '0;
    else      occupancy <= nextOcc;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [OCC_W-1:0] killPop;

  always_comb begin
    killPop = '0;
    for (int i = 0; i < DEPTH; i++) killPop = killPop + OCC_W'(v[i] && flush[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      stall_cnt <= stall_cnt + PERF_CNT_W'(in_valid && !in_ready);
      kill_cnt  <= kill_cnt + PERF_CNT_W'(killPop);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_array.sv
// Directed bench for pipe_stage_array (DEPTH=4); perf counters checked when PIPE_STAGE_PERF_EN is set.
module tb_pipe_stage_array;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = occW(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] flush = '0;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt, kill_cnt;
  logic [PERF_CNT_W-1:0] snap;
`endif

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  pipe_stage_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = '0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic push(input logic [WIDTH-1:0] val);
    in_valid = 1'b1;
    in_data  = val;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int expOv [7] = '{0, 0, 0, 1, 1, 1, 0};
  int expOd [7] = '{0, 0, 0, 1, 2, 3, 0};
  int expOcc[7] = '{1, 2, 3, 3, 2, 1, 0};

  initial begin
    // reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_occ",       occupancy, 0);
    @(negedge clk) rst = 1'b1;

    // streaming 1,2,3 with no backpressure
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_data  = WIDTH'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk($sformatf("stream_ov_%0d", c), out_valid, expOv[c]);
      chk($sformatf("stream_occ_%0d", c), occupancy, expOcc[c]);
      if (expOv[c] != 0) chk($sformatf("stream_od_%0d", c), out_data, expOd[c]);
    end

    // backpressure: 4 accepted, 5th refused, release shifts in the same cycle
    doReset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h11 + k);
      #1;
      chk($sformatf("bp_in_ready_%0d", k), in_ready, (k < 4) ? 1 : 0);
      if (k < 4) tick();
    end
    chk("bp_occ_full", occupancy, 4);
    chk("bp_out_data", out_data, 32'h11);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_ripple", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_occ_shift", occupancy, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_order_ov_%0d", k), out_valid, 1);
      chk($sformatf("bp_order_od_%0d", k), out_data, 32'h12 + k);
      tick();
    end
    chk("bp_drained_ov", out_valid, 0);
    chk("bp_drained_occ", occupancy, 0);

    // bubble collapse
    doReset();
    push(32'hA);
    tick();
    tick();
    push(32'hB);
    repeat (4) tick();
    chk("bub_occ", occupancy, 2);
    chk("bub_od", out_data, 32'hA);
    chk("bub_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("bub_next_ov", out_valid, 1);
    chk("bub_next_od", out_data, 32'hB);
    chk("bub_next_occ", occupancy, 1);
    tick();
    chk("bub_empty_ov", out_valid, 0);

    // flush middle stages of a full pipe
    doReset();
    push(32'hD0);
    push(32'hC0);
    push(32'hB0);
    push(32'hA0);
    chk("fl_full_occ", occupancy, 4);
    flush = 4'b0110;
    tick();
    flush = '0;
    chk("fl_occ", occupancy, 2);
    chk("fl_od", out_data, 32'hD0);
    repeat (3) tick();
    chk("fl_collapse_occ", occupancy, 2);
    out_ready = 1'b1;
    tick();
    chk("fl_survivor_ov", out_valid, 1);
    chk("fl_survivor_od", out_data, 32'hA0);
    tick();
    chk("fl_empty_ov", out_valid, 0);

    // input accepted alongside flush[0] survives, old stage-0 entry dies
    out_ready = 1'b0;
    push(32'h55);
    in_valid = 1'b1;
    in_data  = 32'h66;
    flush    = 4'b0001;
    tick();
    in_valid = 1'b0;
    flush    = '0;
    chk("fl0_occ", occupancy, 1);
    repeat (3) tick();
    chk("fl0_ov", out_valid, 1);
    chk("fl0_od", out_data, 32'h66);
    chk("fl0_occ_end", occupancy, 1);

    // async reset mid-stream
    doReset();
    push(32'h1);
    push(32'h2);
    push(32'h3);
    chk("ar_pre_occ", occupancy, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_od", out_data, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_in_ready", in_ready, 1);
    #1 rst = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    doReset();
    chk("perf_rst_stall", stall_cnt, 0);
    chk("perf_rst_kill", kill_cnt, 0);
    repeat (4) push(32'h77);
    snap = stall_cnt;
    in_valid = 1'b1;
    repeat (7) tick();
    in_valid = 1'b0;
    chk("perf_stall", stall_cnt - snap, 7);
    snap = kill_cnt;
    flush = 4'b0111;
    tick();
    flush = '0;
    chk("perf_kill", kill_cnt - snap, 3);
    chk("perf_kill_occ", occupancy, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
